// File: rtl/param_memory_if.sv
// Request/response bundle between the control unit and param_memory.
// The memory takes the slave side; the control unit (or bench) drives the master side.
interface param_memory_if #(
   parameter int DATA_W = 18,
   parameter int ADDR_W = 13
);
   logic              re_en;
   logic              wr_en;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] inD;
   logic [DATA_W-1:0] outD;
   logic              rd_valid;
   logic              ready;
   logic              err;

   modport master (
      output re_en, wr_en, address, inD,
      input  outD, rd_valid, ready, err
   );

   modport slave (
      input  re_en, wr_en, address, inD,
      output outD, rd_valid, ready, err
   );
endinterface

// File: rtl/param_memory.sv
// Parametrised single-port data/program store with a post-reset clearing sweep,
// 1- or 2-clock read latency with a read-valid strobe, and an illegal-request flag.
module param_memory #(
   parameter int                DATA_W   = 18,
   parameter int                ADDR_W   = 13,
   parameter int                DEPTH    = 128,
   parameter int                READ_LAT = 1,
   parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
   input  logic          i_clk,
   input  logic          i_rst,
   param_memory_if.slave bus
);

   localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W-1:0]  r_init_cnt;
   logic [IDX_W-1:0]  w_init_cnt_nxt;
   logic              r_ready;
   logic              r_rd_valid;
   logic              r_err;
   logic [DATA_W-1:0] r_outD;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_in_range;
   logic [IDX_W-1:0]  w_idx;
   logic              w_mem_we;
   logic [IDX_W-1:0]  w_mem_waddr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic              w_rd_acc;
   logic [DATA_W-1:0] w_rd_data;
   logic              w_err_nxt;
   logic              w_fin_vld;
   logic [DATA_W-1:0] w_fin_data;

   // Upper address bits only take part in the range check, never in indexing.
   assign w_in_range = ({1'b0, bus.address} < DEPTH_C);
   assign w_idx      = bus.address[IDX_W-1:0];

   // Next-state, single write port selection and request decode.
   always_comb begin
      w_state_nxt    = r_state;
      w_init_cnt_nxt = r_init_cnt;
      w_mem_we       = 1'b0;
      w_mem_waddr    = r_init_cnt;
      w_mem_wdata    = INIT_VAL;
      w_rd_acc       = 1'b0;
      w_err_nxt      = 1'b0;
      if (i_rst) begin
         w_state_nxt    = ST_INIT;
         w_init_cnt_nxt = {IDX_W{1'b0}};
      end else begin
         case (r_state)
            ST_INIT: begin
               w_mem_we  = 1'b1;
               w_err_nxt = bus.re_en | bus.wr_en;
               if (r_init_cnt == LAST_IDX) begin
                  w_state_nxt    = ST_RUN;
                  w_init_cnt_nxt = {IDX_W{1'b0}};
               end else begin
                  w_init_cnt_nxt = r_init_cnt + IDX_W'(1'b1);
               end
            end
            ST_RUN: begin
               if (bus.re_en && bus.wr_en) begin
                  w_err_nxt = 1'b1;
               end else if (bus.re_en) begin
                  // Out-of-range reads still complete, returning zero data.
                  w_rd_acc  = 1'b1;
                  w_err_nxt = ~w_in_range;
               end else if (bus.wr_en) begin
                  if (w_in_range) begin
                     w_mem_we    = 1'b1;
                     w_mem_waddr = w_idx;
                     w_mem_wdata = bus.inD;
                  end else begin
                     w_err_nxt = 1'b1;
                  end
               end else begin
                  w_err_nxt = 1'b0;
               end
            end
            default: begin
               w_state_nxt    = ST_INIT;
               w_init_cnt_nxt = {IDX_W{1'b0}};
            end
         endcase
      end
   end

   // Array lookup for the read accepted at this edge.
   always_comb begin
      w_rd_data = {DATA_W{1'b0}};
      if (w_in_range) begin
         w_rd_data = r_mem[w_idx];
      end else begin
         w_rd_data = {DATA_W{1'b0}};
      end
   end

   // FSM state, sweep counter and ready flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_INIT;
         r_init_cnt <= {IDX_W{1'b0}};
         r_ready    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_cnt <= w_init_cnt_nxt;
         r_ready    <= (w_state_nxt == ST_RUN);
      end
   end

   // Storage array; the sweep and normal writes share the one write port.
   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_waddr] <= w_mem_wdata;
      end
   end

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic              r_p_vld;
         logic [DATA_W-1:0] r_p_data;

         // Extra pipeline stage for two-clock read latency.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_p_vld  <= 1'b0;
               r_p_data <= {DATA_W{1'b0}};
            end else begin
               r_p_vld  <= w_rd_acc;
               r_p_data <= w_rd_data;
            end
         end

         assign w_fin_vld  = r_p_vld;
         assign w_fin_data = r_p_data;
      end else begin : g_lat1
         assign w_fin_vld  = w_rd_acc;
         assign w_fin_data = w_rd_data;
      end
   endgenerate

   // Response registers; outD only moves when a read completes.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_valid <= 1'b0;
         r_err      <= 1'b0;
         r_outD     <= {DATA_W{1'b0}};
      end else begin
         r_rd_valid <= w_fin_vld;
         r_err      <= w_err_nxt;
         if (w_fin_vld) begin
            r_outD <= w_fin_data;
         end
      end
   end

   assign bus.outD     = r_outD;
   assign bus.rd_valid = r_rd_valid;
   assign bus.ready    = r_ready;
   assign bus.err      = r_err;

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory: a READ_LAT=1 and a READ_LAT=2 instance share one stimulus stream.
module tb_param_memory;

   logic        clk;
   logic        rst;
   logic        re;
   logic        wr;
   logic [12:0] addr;
   logic [17:0] ind;
   int          checks;
   int          failures;

   param_memory_if #(.DATA_W(18), .ADDR_W(13)) bus1 ();
   param_memory_if #(.DATA_W(18), .ADDR_W(13)) bus2 ();

   assign bus1.re_en   = re;
   assign bus1.wr_en   = wr;
   assign bus1.address = addr;
   assign bus1.inD     = ind;
   assign bus2.re_en   = re;
   assign bus2.wr_en   = wr;
   assign bus2.address = addr;
   assign bus2.inD     = ind;

   param_memory #(.DATA_W(18), .ADDR_W(13), .DEPTH(128), .READ_LAT(1), .INIT_VAL(18'h00000)) u_lat1 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus1.slave)
   );

   param_memory #(.DATA_W(18), .ADDR_W(13), .DEPTH(128), .READ_LAT(2), .INIT_VAL(18'h00000)) u_lat2 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus2.slave)
   );

   // Observation word: {rd_valid, err, ready, outD}
   logic [20:0] obs1;
   logic [20:0] obs2;
   assign obs1 = {bus1.rd_valid, bus1.err, bus1.ready, bus1.outD};
   assign obs2 = {bus2.rd_valid, bus2.err, bus2.ready, bus2.outD};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; re = 1'b1; wr = 1'b1; addr = 13'd5; ind = 18'd9;
      cyc(); cyc(); cyc();
      checks++;
      if (obs1 !== {1'b0, 1'b0, 1'b0, 18'h0}) begin
         failures++; $display("FAIL reset_lat1 got=%h exp=%h", obs1, {1'b0, 1'b0, 1'b0, 18'h0});
      end
      checks++;
      if (obs2 !== {1'b0, 1'b0, 1'b0, 18'h0}) begin
         failures++; $display("FAIL reset_lat2 got=%h exp=%h", obs2, {1'b0, 1'b0, 1'b0, 18'h0});
      end
      re = 1'b0; wr = 1'b0; addr = 13'd0; ind = 18'd0;
   endtask

   task automatic test_init_sweep();
      int early;
      int a;
      logic [12:0] rd_addrs [3];
      rd_addrs[0] = 13'd0; rd_addrs[1] = 13'd64; rd_addrs[2] = 13'd127;
      early = 0;
      rst = 1'b0;
      for (int i = 1; i <= 128; i++) begin
         cyc();
         if (i < 128 && (bus1.ready !== 1'b0 || bus2.ready !== 1'b0)) early++;
      end
      checks++;
      if (early !== 0) begin
         failures++; $display("FAIL init_early_ready got=%0d exp=0", early);
      end
      checks++;
      if (obs1 !== {1'b0, 1'b0, 1'b1, 18'h0} || obs2 !== {1'b0, 1'b0, 1'b1, 18'h0}) begin
         failures++; $display("FAIL init_ready_128 got=%h/%h exp=%h", obs1, obs2, {1'b0, 1'b0, 1'b1, 18'h0});
      end
      for (int k = 0; k < 3; k++) begin
         a = int'(rd_addrs[k]);
         re = 1'b1; addr = rd_addrs[k];
         cyc();
         checks++;
         if (obs1 !== {1'b1, 1'b0, 1'b1, 18'h0} || obs2 !== {1'b0, 1'b0, 1'b1, 18'h0}) begin
            failures++; $display("FAIL init_read_e1 addr=%0d got=%h/%h exp=%h/%h", a, obs1, obs2,
                                 {1'b1, 1'b0, 1'b1, 18'h0}, {1'b0, 1'b0, 1'b1, 18'h0});
         end
         re = 1'b0;
         cyc();
         checks++;
         if (obs1 !== {1'b0, 1'b0, 1'b1, 18'h0} || obs2 !== {1'b1, 1'b0, 1'b1, 18'h0}) begin
            failures++; $display("FAIL init_read_e2 addr=%0d got=%h/%h exp=%h/%h", a, obs1, obs2,
                                 {1'b0, 1'b0, 1'b1, 18'h0}, {1'b1, 1'b0, 1'b1, 18'h0});
         end
      end
   endtask

   task automatic test_write_read();
      wr = 1'b1; addr = 13'd20; ind = 18'h00007;
      cyc();
      checks++;
      if (obs1 !== {1'b0, 1'b0, 1'b1, 18'h0} || obs2 !== {1'b0, 1'b0, 1'b1, 18'h0}) begin
         failures++; $display("FAIL wr20_no_strobe got=%h/%h exp=%h", obs1, obs2, {1'b0, 1'b0, 1'b1, 18'h0});
      end
      wr = 1'b0; re = 1'b1;
      cyc();
      checks++;
      if (obs1 !== {1'b1, 1'b0, 1'b1, 18'h7} || obs2 !== {1'b0, 1'b0, 1'b1, 18'h0}) begin
         failures++; $display("FAIL rd20_e1 got=%h/%h exp=%h/%h", obs1, obs2,
                              {1'b1, 1'b0, 1'b1, 18'h7}, {1'b0, 1'b0, 1'b1, 18'h0});
      end
      re = 1'b0;
      cyc();
      checks++;
      if (obs1 !== {1'b0, 1'b0, 1'b1, 18'h7} || obs2 !== {1'b1, 1'b0, 1'b1, 18'h7}) begin
         failures++; $display("FAIL rd20_e2_hold got=%h/%h exp=%h/%h", obs1, obs2,
                              {1'b0, 1'b0, 1'b1, 18'h7}, {1'b1, 1'b0, 1'b1, 18'h7});
      end
   endtask

   task automatic test_back_to_back();
      logic [17:0] vals [4];
      logic [20:0] exp1;
      logic [20:0] exp2;
      vals[0] = 18'd7; vals[1] = 18'd11; vals[2] = 18'd22; vals[3] = 18'd33;
      for (int k = 1; k <= 3; k++) begin
         wr = 1'b1; addr = 13'(k); ind = vals[k];
         cyc();
      end
      wr = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         re = (e <= 3); addr = 13'(e);
         cyc();
         exp1 = (e <= 3) ? {1'b1, 1'b0, 1'b1, vals[e]} : {1'b0, 1'b0, 1'b1, vals[3]};
         if (e == 1)      exp2 = {1'b0, 1'b0, 1'b1, vals[0]};
         else if (e <= 4) exp2 = {1'b1, 1'b0, 1'b1, vals[e-1]};
         else             exp2 = {1'b0, 1'b0, 1'b1, vals[3]};
         checks++;
         if (obs1 !== exp1 || obs2 !== exp2) begin
            failures++; $display("FAIL b2b_edge%0d got=%h/%h exp=%h/%h", e, obs1, obs2, exp1, exp2);
         end
      end
      re = 1'b0;
   endtask

   task automatic test_conflict();
      wr = 1'b1; addr = 13'd5; ind = 18'h00155;
      cyc();
      re = 1'b1; wr = 1'b1; addr = 13'd5; ind = 18'd9;
      cyc();
      checks++;
      if (obs1 !== {1'b0, 1'b1, 1'b1, 18'd33} || obs2 !== {1'b0, 1'b1, 1'b1, 18'd33}) begin
         failures++; $display("FAIL conflict_err got=%h/%h exp=%h", obs1, obs2, {1'b0, 1'b1, 1'b1, 18'd33});
      end
      re = 1'b0; wr = 1'b0;
      cyc();
      checks++;
      if (obs1 !== {1'b0, 1'b0, 1'b1, 18'd33} || obs2 !== {1'b0, 1'b0, 1'b1, 18'd33}) begin
         failures++; $display("FAIL conflict_after got=%h/%h exp=%h", obs1, obs2, {1'b0, 1'b0, 1'b1, 18'd33});
      end
      re = 1'b1;
      cyc();
      re = 1'b0;
      cyc();
      checks++;
      if (obs1 !== {1'b0, 1'b0, 1'b1, 18'h155} || obs2 !== {1'b1, 1'b0, 1'b1, 18'h155}) begin
         failures++; $display("FAIL conflict_mem5 got=%h/%h exp=%h/%h", obs1, obs2,
                              {1'b0, 1'b0, 1'b1, 18'h155}, {1'b1, 1'b0, 1'b1, 18'h155});
      end
   endtask

   task automatic test_out_of_range();
      logic [12:0] seq_addr [4];
      logic [20:0] exp1 [4];
      logic [20:0] exp2 [4];
      seq_addr[0] = 13'd200; seq_addr[1] = 13'd128; seq_addr[2] = 13'd127; seq_addr[3] = 13'd0;
      exp1[0] = {1'b1, 1'b1, 1'b1, 18'h0};   exp2[0] = {1'b0, 1'b1, 1'b1, 18'h155};
      exp1[1] = {1'b1, 1'b1, 1'b1, 18'h0};   exp2[1] = {1'b1, 1'b1, 1'b1, 18'h0};
      exp1[2] = {1'b1, 1'b0, 1'b1, 18'h0};   exp2[2] = {1'b1, 1'b0, 1'b1, 18'h0};
      exp1[3] = {1'b0, 1'b0, 1'b1, 18'h0};   exp2[3] = {1'b1, 1'b0, 1'b1, 18'h0};
      for (int e = 0; e < 4; e++) begin
         re = (e < 3); addr = seq_addr[e];
         cyc();
         checks++;
         if (obs1 !== exp1[e] || obs2 !== exp2[e]) begin
            failures++; $display("FAIL oor_read_step%0d got=%h/%h exp=%h/%h", e, obs1, obs2, exp1[e], exp2[e]);
         end
      end
      re = 1'b0; wr = 1'b1; addr = 13'd200; ind = 18'h3ffff;
      cyc();
      checks++;
      if (obs1 !== {1'b0, 1'b1, 1'b1, 18'h0} || obs2 !== {1'b0, 1'b1, 1'b1, 18'h0}) begin
         failures++; $display("FAIL oor_write_err got=%h/%h exp=%h", obs1, obs2, {1'b0, 1'b1, 1'b1, 18'h0});
      end
      wr = 1'b0; re = 1'b1; addr = 13'd72;
      cyc();
      re = 1'b0;
      cyc();
      checks++;
      if (obs1 !== {1'b0, 1'b0, 1'b1, 18'h0} || obs2 !== {1'b1, 1'b0, 1'b1, 18'h0}) begin
         failures++; $display("FAIL oor_write_alias72 got=%h/%h exp=%h/%h", obs1, obs2,
                              {1'b0, 1'b0, 1'b1, 18'h0}, {1'b1, 1'b0, 1'b1, 18'h0});
      end
   endtask

   task automatic test_reset_mid_read();
      int n;
      int vld_seen;
      n = 0; vld_seen = 0;
      re = 1'b1; addr = 13'd20;
      cyc();
      checks++;
      if (obs1 !== {1'b1, 1'b0, 1'b1, 18'h7} || obs2 !== {1'b0, 1'b0, 1'b1, 18'h0}) begin
         failures++; $display("FAIL mid_read_issue got=%h/%h exp=%h/%h", obs1, obs2,
                              {1'b1, 1'b0, 1'b1, 18'h7}, {1'b0, 1'b0, 1'b1, 18'h0});
      end
      rst = 1'b1;
      cyc();
      checks++;
      if (obs1 !== {1'b0, 1'b0, 1'b0, 18'h0} || obs2 !== {1'b0, 1'b0, 1'b0, 18'h0}) begin
         failures++; $display("FAIL mid_read_reset got=%h/%h exp=%h", obs1, obs2, {1'b0, 1'b0, 1'b0, 18'h0});
      end
      rst = 1'b0; re = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         re = (i == 3);
         cyc();
         if (bus1.rd_valid !== 1'b0 || bus2.rd_valid !== 1'b0) vld_seen++;
         if (i == 3) begin
            checks++;
            if ({bus1.err, bus2.err} !== 2'b11) begin
               failures++; $display("FAIL init_req_err got=%b exp=11", {bus1.err, bus2.err});
            end
         end
         if (i == 4) begin
            checks++;
            if ({bus1.err, bus2.err} !== 2'b00) begin
               failures++; $display("FAIL init_req_err_clear got=%b exp=00", {bus1.err, bus2.err});
            end
         end
         if (bus1.ready === 1'b1) begin
            n = i;
            break;
         end
      end
      re = 1'b0;
      checks++;
      if (n !== 128 || bus2.ready !== 1'b1) begin
         failures++; $display("FAIL reinit_ready_edges got=%0d exp=128", n);
      end
      checks++;
      if (vld_seen !== 0) begin
         failures++; $display("FAIL reinit_stray_valid got=%0d exp=0", vld_seen);
      end
      re = 1'b1; addr = 13'd20;
      cyc();
      re = 1'b0;
      cyc();
      checks++;
      if (obs1 !== {1'b0, 1'b0, 1'b1, 18'h0} || obs2 !== {1'b1, 1'b0, 1'b1, 18'h0}) begin
         failures++; $display("FAIL reinit_cleared20 got=%h/%h exp=%h/%h", obs1, obs2,
                              {1'b0, 1'b0, 1'b1, 18'h0}, {1'b1, 1'b0, 1'b1, 18'h0});
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; re = 1'b0; wr = 1'b0; addr = 13'd0; ind = 18'd0;
      test_reset();
      test_init_sweep();
      test_write_read();
      test_back_to_back();
      test_conflict();
      test_out_of_range();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

endmodule
